oled_fill_arbiter: RTL and testbench

- Two-requester scheduler for the SSD1351 128x128 SPI OLED.
- Each requester asks for a solid-colour rectangle fill. The block arbitrates, then sequences the window commands (column address, row address, write RAM), streams the 16-bit pixel words, and drives the SPI pins itself.
- It sits after the display init sequencer: the display is already initialised when requests arrive, and the spi_* outputs are muxed with the init path outside this block.

---
 rtl/oled_fill_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_oled_fill_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_fill_arbiter.sv
// oled_fill_arbiter: two-requester solid-rectangle filler for the SSD1351 OLED, driving SPI at clk/2.
// Optional macro OLED_FILL_RR_EN selects round-robin tie breaking; without it req0 always wins ties.
module oled_fill_arbiter #(
    parameter int c_x_size = 128,
    parameter int c_y_size = 128,
    parameter int c_x_bits = $clog2(c_x_size),
    parameter int c_y_bits = $clog2(c_y_size)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic [c_x_bits-1:0] x0_0,
    input  logic [c_x_bits-1:0] x1_0,
    input  logic [c_y_bits-1:0] y0_0,
    input  logic [c_y_bits-1:0] y1_0,
    input  logic [15:0]         color_0,
    input  logic [c_x_bits-1:0] x0_1,
    input  logic [c_x_bits-1:0] x1_1,
    input  logic [c_y_bits-1:0] y0_1,
    input  logic [c_y_bits-1:0] y1_1,
    input  logic [15:0]         color_1,
    output logic                ack0,
    output logic                ack1,
    output logic                err0,
    output logic                err1,
    output logic                done0,
    output logic                done1,
    output logic                busy,
    output logic                spi_csn,
    output logic                spi_clk,
    output logic                spi_mosi,
    output logic                spi_dc
);

    localparam logic [7:0] c_cmd_col = 8'h15;
    localparam logic [7:0] c_cmd_row = 8'h75;
    localparam logic [7:0] c_cmd_wr  = 8'h5C;

    typedef enum logic [3:0] {
        IDLE, GRANT, CMD_COL, A_C0, A_C1, CMD_ROW, A_R0, A_R1, CMD_WR, PX_HI, PX_LO, FIN
    } state_t;

    state_t state, state_next;

    logic [3:0]          cyc;
    logic [c_x_bits-1:0] x0_q, x1_q, x_cnt;
    logic [c_y_bits-1:0] y0_q, y1_q, y_cnt;
    logic [15:0]         color_q;
    logic                gnt_q;

    logic       any_req, pick1, take;
    logic       in_byte, byte_end, win_ok, last_px;
    logic [7:0] tx_byte;
    logic       tx_dc;

    assign any_req  = req0 | req1;
    // FIN arbitrates too, so a pending request is granted on the very next cycle.
    assign take     = any_req && ((state == IDLE) || (state == FIN));
    assign in_byte  = (state != IDLE) && (state != GRANT) && (state != FIN);
    assign byte_end = (cyc == 4'd15);
    assign win_ok   = (x0_q <= x1_q) && (y0_q <= y1_q);
    assign last_px  = (x_cnt == x1_q) && (y_cnt == y1_q);

`ifdef OLED_FILL_RR_EN
    logic last_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_gnt <= 1'b1;
        else if (take)
            last_gnt <= pick1;
    end

    assign pick1 = req1 && (!req0 || !last_gnt);
`else
    assign pick1 = req1 && !req0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc     <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            color_q <= '0;
            gnt_q   <= 1'b0;
        end else begin
            if (take) begin
                gnt_q   <= pick1;
                x0_q    <= pick1 ? x0_1 : x0_0;
                x1_q    <= pick1 ? x1_1 : x1_0;
                y0_q    <= pick1 ? y0_1 : y0_0;
                y1_q    <= pick1 ? y1_1 : y1_0;
                x_cnt   <= pick1 ? x0_1 : x0_0;
                y_cnt   <= pick1 ? y0_1 : y0_0;
                color_q <= pick1 ? color_1 : color_0;
            end
            cyc <= in_byte ? cyc + 4'd1 : 4'd0;
            // Raster walk: X wraps back to x0 and bumps Y at the end of each row.
            if ((state == PX_LO) && byte_end && !last_px) begin
                if (x_cnt == x1_q) begin
                    x_cnt <= x0_q;
                    y_cnt <= y_cnt + c_y_bits'(1);
                end else begin
                    x_cnt <= x_cnt + c_x_bits'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT:   state_next = win_ok ? CMD_COL : IDLE;
            CMD_COL: if (byte_end) state_next = A_C0;
            A_C0:    if (byte_end) state_next = A_C1;
            A_C1:    if (byte_end) state_next = CMD_ROW;
            CMD_ROW: if (byte_end) state_next = A_R0;
            A_R0:    if (byte_end) state_next = A_R1;
            A_R1:    if (byte_end) state_next = CMD_WR;
            CMD_WR:  if (byte_end) state_next = PX_HI;
            PX_HI:   if (byte_end) state_next = PX_LO;
            PX_LO:   if (byte_end) state_next = last_px ? FIN : PX_HI;
            FIN:     state_next = any_req ? GRANT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack0     = 1'b0;
        ack1     = 1'b0;
        err0     = 1'b0;
        err1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        busy     = (state != IDLE);
        tx_byte  = 8'h00;
        tx_dc    = 1'b0;
        spi_csn  = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_dc   = 1'b0;
        case (state)
            GRANT: begin
                ack0 = !gnt_q;
                ack1 = gnt_q;
                err0 = !gnt_q && !win_ok;
                err1 = gnt_q && !win_ok;
            end
            CMD_COL: tx_byte = c_cmd_col;
            A_C0:    begin tx_byte = 8'(x0_q); tx_dc = 1'b1; end
            A_C1:    begin tx_byte = 8'(x1_q); tx_dc = 1'b1; end
            CMD_ROW: tx_byte = c_cmd_row;
            A_R0:    begin tx_byte = 8'(y0_q); tx_dc = 1'b1; end
            A_R1:    begin tx_byte = 8'(y1_q); tx_dc = 1'b1; end
            CMD_WR:  tx_byte = c_cmd_wr;
            PX_HI:   begin tx_byte = color_q[15:8]; tx_dc = 1'b1; end
            PX_LO:   begin tx_byte = color_q[7:0];  tx_dc = 1'b1; end
            FIN: begin
                done0 = !gnt_q;
                done1 = gnt_q;
            end
            default: ;
        endcase
        // Each bit spans two clk cycles: low half then high half, display samples on the rise.
        if (in_byte) begin
            spi_csn  = 1'b0;
            spi_clk  = cyc[0];
            spi_mosi = tx_byte[3'd7 - cyc[3:1]];
            spi_dc   = tx_dc;
        end
    end

endmodule

// File: tb/tb_oled_fill_arbiter.sv
// tb_oled_fill_arbiter: randomized self-checking bench; a byte-stream model built from window
// geometry predicts every SPI byte, csn-low length and the ack/err/done handshakes.
module tb_oled_fill_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [6:0]  x0_0, x1_0, x0_1, x1_1;
    logic [6:0]  y0_0, y1_0, y0_1, y1_1;
    logic [15:0] color_0, color_1;
    logic        ack0, ack1, err0, err1, done0, done1, busy;
    logic        spi_csn, spi_clk, spi_mosi, spi_dc;

    int n_checks = 0;
    int n_fail   = 0;

    oled_fill_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .x0_0(x0_0), .x1_0(x1_0), .y0_0(y0_0), .y1_0(y1_0), .color_0(color_0),
        .x0_1(x0_1), .x1_1(x1_1), .y0_1(y0_1), .y1_1(y1_1), .color_1(color_1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .done0(done0), .done1(done1), .busy(busy),
        .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc)
    );

    always #5 clk = ~clk;

    int unsigned cyc_no = 0;
    logic [7:0]  cap_byte[$];
    logic        cap_dc[$];
    int unsigned csn_low = 0;
    int          dc_bad  = 0;
    int          ack_id[$];
    logic        ack_err[$];
    int unsigned ack_cyc[$];
    int          done_id[$];
    int unsigned done_cyc[$];

    logic [7:0]  exp_byte[$];
    logic        exp_dc[$];
    int          cap_idx = 0;
    int          exp_idx = 0;
    int          model_last = 1;

    logic [6:0]  wx0[2], wx1[2], wy0[2], wy1[2];
    logic [15:0] wcol[2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc_no++;
    end

    // SPI receiver and handshake logger, sampling on the falling clk edge.
    initial begin
        int         bit_cnt;
        logic [7:0] shreg;
        logic       byte_dc;
        bit_cnt = 0;
        shreg   = '0;
        byte_dc = 1'b0;
        forever begin
            @(negedge clk);
            if (!spi_csn) csn_low++;
            if (spi_csn || reset) begin
                bit_cnt = 0;
            end else if (spi_clk) begin
                if (bit_cnt == 0) byte_dc = spi_dc;
                else if (spi_dc !== byte_dc) dc_bad++;
                shreg = {shreg[6:0], spi_mosi};
                bit_cnt++;
                if (bit_cnt == 8) begin
                    cap_byte.push_back(shreg);
                    cap_dc.push_back(byte_dc);
                    bit_cnt = 0;
                end
            end
            if (ack0) begin ack_id.push_back(0); ack_err.push_back(err0); ack_cyc.push_back(cyc_no); end
            if (ack1) begin ack_id.push_back(1); ack_err.push_back(err1); ack_cyc.push_back(cyc_no); end
            if (done0) begin done_id.push_back(0); done_cyc.push_back(cyc_no); end
            if (done1) begin done_id.push_back(1); done_cyc.push_back(cyc_no); end
        end
    end

    // Reference: expected bytes straight from the window geometry; returns csn-low cycles.
    function automatic int model_fill(input int id, input int limit);
        int n, k;
        logic [7:0] seq[$];
        logic       dcs[$];
        if (wx0[id] > wx1[id] || wy0[id] > wy1[id]) return 0;
        n = (int'(wx1[id]) - int'(wx0[id]) + 1) * (int'(wy1[id]) - int'(wy0[id]) + 1);
        seq = '{8'h15, {1'b0, wx0[id]}, {1'b0, wx1[id]}, 8'h75, {1'b0, wy0[id]}, {1'b0, wy1[id]}, 8'h5C};
        dcs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int p = 0; p < n; p++) begin
            seq.push_back(wcol[id][15:8]); dcs.push_back(1'b1);
            seq.push_back(wcol[id][7:0]);  dcs.push_back(1'b1);
        end
        k = (limit < seq.size()) ? limit : seq.size();
        for (int i = 0; i < k; i++) begin
            exp_byte.push_back(seq[i]);
            exp_dc.push_back(dcs[i]);
        end
        return 16 * (7 + 2 * n);
    endfunction

    task automatic check_stream(input string tag);
        int nc, ne;
        nc = cap_byte.size() - cap_idx;
        ne = exp_byte.size() - exp_idx;
        checkOutput($sformatf("%s_nbytes", tag), nc, ne);
        for (int i = 0; i < nc && i < ne; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        {23'd0, cap_dc[cap_idx+i], cap_byte[cap_idx+i]},
                        {23'd0, exp_dc[exp_idx+i], exp_byte[exp_idx+i]});
        cap_idx = cap_byte.size();
        exp_idx = exp_byte.size();
    endtask

    task automatic applyStimulus(input int id, input logic [6:0] xa, input logic [6:0] xb,
                                 input logic [6:0] ya, input logic [6:0] yb, input logic [15:0] col);
        wx0[id] = xa; wx1[id] = xb; wy0[id] = ya; wy1[id] = yb; wcol[id] = col;
        if (id == 0) begin
            x0_0 = xa; x1_0 = xb; y0_0 = ya; y1_0 = yb; color_0 = col;
        end else begin
            x0_1 = xa; x1_1 = xb; y0_1 = ya; y1_1 = yb; color_1 = col;
        end
    endtask

    // Requester behaviour: req already high; wait for ack, then drop req on the next cycle.
    task automatic requester(input int id, output int unsigned got_cyc);
        bit seen;
        seen = 0;
        got_cyc = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if ((id == 0) ? ack0 : ack1) begin
                seen = 1;
                got_cyc = cyc_no;
            end
        end
        if (!seen) checkOutput($sformatf("ack%0d_timeout", id), 0, 1);
        @(posedge clk);
        #1;
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) checkOutput("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput(tag, {21'd0, busy, ack0, ack1, err0, err1, done0, done1,
                          spi_csn, spi_clk, spi_mosi, spi_dc}, 32'h008);
    endtask

    task automatic run_single(input string tag, input int id);
        int unsigned raise_c, got, s_csn;
        int s_ack, s_done, exp_csn;
        bit valid;
        s_ack = ack_id.size(); s_done = done_id.size(); s_csn = csn_low;
        @(posedge clk);
        #1;
        raise_c = cyc_no;
        if (id == 0) req0 = 1'b1; else req1 = 1'b1;
        requester(id, got);
        checkOutput($sformatf("%s_ack_latency", tag), got - raise_c, 1);
        wait_idle();
        valid = (wx0[id] <= wx1[id]) && (wy0[id] <= wy1[id]);
        exp_csn = model_fill(id, 1 << 20);
        model_last = id;
        checkOutput($sformatf("%s_nack", tag), ack_id.size() - s_ack, 1);
        if (ack_id.size() > s_ack) begin
            checkOutput($sformatf("%s_ack_id", tag), ack_id[s_ack], id);
            checkOutput($sformatf("%s_err", tag), ack_err[s_ack], !valid);
        end
        checkOutput($sformatf("%s_ndone", tag), done_id.size() - s_done, valid ? 1 : 0);
        if (valid && done_id.size() > s_done)
            checkOutput($sformatf("%s_done_id", tag), done_id[s_done], id);
        checkOutput($sformatf("%s_csn_low", tag), csn_low - s_csn, exp_csn);
        check_stream(tag);
    endtask

    task automatic run_tie(input string tag);
        int unsigned raise_c, g0, g1, s_csn;
        int s_ack, s_done, first, second, exp_csn;
`ifdef OLED_FILL_RR_EN
        first = 1 - model_last;
`else
        first = 0;
`endif
        second = 1 - first;
        s_ack = ack_id.size(); s_done = done_id.size(); s_csn = csn_low;
        @(posedge clk);
        #1;
        raise_c = cyc_no;
        req0 = 1'b1;
        req1 = 1'b1;
        fork
            requester(0, g0);
            requester(1, g1);
        join
        wait_idle();
        exp_csn = model_fill(first, 1 << 20);
        exp_csn += model_fill(second, 1 << 20);
        model_last = second;
        checkOutput($sformatf("%s_nack", tag), ack_id.size() - s_ack, 2);
        checkOutput($sformatf("%s_ndone", tag), done_id.size() - s_done, 2);
        if (ack_id.size() >= s_ack + 2 && done_id.size() >= s_done + 2) begin
            checkOutput($sformatf("%s_first_id", tag), ack_id[s_ack], first);
            checkOutput($sformatf("%s_first_lat", tag), ack_cyc[s_ack] - raise_c, 1);
            checkOutput($sformatf("%s_second_id", tag), ack_id[s_ack+1], second);
            checkOutput($sformatf("%s_back2back", tag), ack_cyc[s_ack+1] - done_cyc[s_done], 1);
            checkOutput($sformatf("%s_done_order", tag), {done_id[s_done], done_id[s_done+1]},
                        {first, second});
        end
        checkOutput($sformatf("%s_csn_low", tag), csn_low - s_csn, exp_csn);
        check_stream(tag);
    endtask

    initial begin
        int unsigned got;
        int          s_done, s_cap, xa, xb, ya, yb;
        bit          reached;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle_after_reset");

        applyStimulus(0, 0, 0, 0, 0, 16'hF800);
        run_single("px1x1", 0);

        applyStimulus(1, 5, 3, 0, 0, 16'h1234);
        run_single("bad_x", 1);

        applyStimulus(1, 0, 127, 127, 127, 16'h07E0);
        run_single("full_row", 1);

        applyStimulus(0, 10, 11, 4, 4, 16'hABCD);
        applyStimulus(1, 20, 21, 9, 9, 16'h5A5A);
        run_tie("tie_a");

        applyStimulus(0, 40, 40, 1, 1, 16'h0F0F);
        run_single("solo0", 0);
        applyStimulus(0, 0, 1, 126, 126, 16'hC3C3);
        applyStimulus(1, 126, 127, 0, 0, 16'h3C3C);
        run_tie("tie_b");

        // Abort a 4x4 fill after 20 bytes and make sure it leaves no trace.
        applyStimulus(0, 10, 13, 20, 23, 16'h8421);
        s_done = done_id.size();
        s_cap  = cap_byte.size();
        @(posedge clk);
        #1 req0 = 1'b1;
        requester(0, got);
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            if (cap_byte.size() >= s_cap + 20) reached = 1;
        end
        checkOutput("abort_reached_byte20", reached, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_in_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("abort_no_done", done_id.size() - s_done, 0);
        void'(model_fill(0, 20));
        model_last = 1;
        check_stream("abort");
        run_single("after_abort", 0);

        for (int t = 0; t < 12; t++) begin
            int id;
            id = int'($urandom_range(0, 1));
            xa = int'($urandom_range(0, 127));
            xb = xa + int'($urandom_range(0, 5));
            if (xb > 127) xb = 127;
            ya = int'($urandom_range(0, 127));
            yb = ya + int'($urandom_range(0, 5));
            if (yb > 127) yb = 127;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    xa = int'($urandom_range(1, 127)); xb = int'($urandom_range(0, xa - 1));
                end else begin
                    ya = int'($urandom_range(1, 127)); yb = int'($urandom_range(0, ya - 1));
                end
            end
            applyStimulus(id, 7'(xa), 7'(xb), 7'(ya), 7'(yb), 16'($urandom));
            run_single($sformatf("rand%0d", t), id);
        end

        checkOutput("dc_stable_in_byte", dc_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
